// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase generator: waveform mode codes,
// default widths, the configuration record and the config-update state encoding.
package dds_pkg;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_SAW    = 2'd2;
    localparam logic [1:0] MODE_TRI    = 2'd3;

    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int AMP_W_DEF  = 4;
    localparam int DIV_W_DEF  = 16;

    typedef struct packed {
        logic [ACC_W_DEF-1:0]  ftw;
        logic [ADDR_W_DEF-1:0] pow;
        logic [AMP_W_DEF-1:0]  amp;
        logic [1:0]            mode;
    } dds_cfg_t;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_APPLY = 2'd1,
        CFG_PEND  = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/dds_phase_gen_if.sv
// Configuration channel from the key/display front end into the phase generator.
// Handshake: a word transfers on the clock edge where cfg_valid && cfg_ready; the
// master holds all cfg_* fields stable while cfg_valid is high and not yet accepted.
interface dds_phase_gen_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int AMP_W  = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_ftw;
    logic [ADDR_W-1:0] cfg_pow;
    logic [AMP_W-1:0]  cfg_amp;
    logic [1:0]        cfg_mode;
    logic              cfg_sync;

    modport master (
        output cfg_valid, cfg_ftw, cfg_pow, cfg_amp, cfg_mode, cfg_sync,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ftw, cfg_pow, cfg_amp, cfg_mode, cfg_sync,
        output cfg_ready
    );
endinterface

// File: rtl/dds_wave_shaper.sv
// Final pipeline stage: turns the carried phase (top DATA_W+1 bits) or the ROM word
// into the selected waveform, scales it by amp+1 and registers the DAC sample.
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMP_W  = AMP_W_DEF
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [1:0]        mode_i,
    input  logic [AMP_W-1:0]  amp_i,
    input  logic [DATA_W:0]   phase_i,
    input  logic [DATA_W-1:0] rom_q_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o
);

    localparam int PW = DATA_W + AMP_W + 1;

    logic [DATA_W-1:0] raw;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] scaled;
    logic [AMP_W-1:0]  frac_unused;
    logic              guard_unused;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    always_comb begin
        raw = '0;
        case (mode_i)
            MODE_SINE:   raw = rom_q_i;
            MODE_SQUARE: raw = {DATA_W{phase_i[DATA_W]}};
            MODE_SAW:    raw = phase_i[DATA_W:1];
            default:     raw = phase_i[DATA_W] ? ~phase_i[DATA_W-1:0] : phase_i[DATA_W-1:0];
        endcase
        // amp = all-ones multiplies by 2^AMP_W, so the shift gives unity gain
        prod = PW'(raw) * (PW'(amp_i) + PW'(1));
        {guard_unused, scaled, frac_unused} = prod;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= valid_i;
            if (valid_i) begin
                out_data_q <= scaled;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase generator: divided sample tick, binary phase accumulator with offset,
// 3-clock ROM/shaper pipeline, and immediate or wrap-synchronous reconfiguration.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMP_W  = AMP_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clkin,
    input  logic              rst_n,
    dds_phase_gen_if.slave    cfg,
    input  logic [DIV_W-1:0]  sample_div,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              wrap,
    output cfg_state_e        dbg_state_o
);

    // Only the top PT_W bits of the offset phase are ever consumed downstream.
    localparam int PT_W = (ADDR_W > DATA_W + 1) ? ADDR_W : DATA_W + 1;

    typedef struct packed {
        logic [ACC_W-1:0]  ftw;
        logic [ADDR_W-1:0] pow;
        logic [AMP_W-1:0]  amp;
        logic [1:0]        mode;
    } cfg_rec_t;

    localparam cfg_rec_t CFG_RESET = '{ftw: '0, pow: '0, amp: '1, mode: MODE_SINE};

    cfg_rec_t          act_q, shadow_q;
    cfg_state_e        state_q;
    logic              cfg_ready_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_carry;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              wrap_q;
    logic              tick;
    logic [PT_W-1:0]   p_top;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W:0]   ph1_q, ph2_q;
    logic              v1_q, v2_q;

    // >= rather than == so that lowering sample_div below the count ticks at once
    assign tick      = div_cnt_q >= sample_div;
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    assign {acc_carry, acc_d} = {1'b0, acc_q} + {1'b0, act_q.ftw};
    assign p_top = acc_q[ACC_W-1 -: PT_W] + (PT_W'(act_q.pow) << (PT_W - ADDR_W));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            div_cnt_q   <= '0;
            wrap_q      <= 1'b0;
            act_q       <= CFG_RESET;
            shadow_q    <= CFG_RESET;
            state_q     <= CFG_IDLE;
            cfg_ready_q <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            wrap_q    <= tick & acc_carry;
            if (tick) begin
                acc_q <= acc_d;
            end
            case (state_q)
                CFG_IDLE: begin
                    if (cfg.cfg_valid && cfg_ready_q) begin
                        shadow_q    <= '{ftw: cfg.cfg_ftw, pow: cfg.cfg_pow,
                                         amp: cfg.cfg_amp, mode: cfg.cfg_mode};
                        cfg_ready_q <= 1'b0;
                        state_q     <= cfg.cfg_sync ? CFG_PEND : CFG_APPLY;
                    end
                end
                CFG_APPLY: begin
                    act_q       <= shadow_q;
                    acc_q       <= '0;
                    cfg_ready_q <= 1'b1;
                    state_q     <= CFG_IDLE;
                end
                CFG_PEND: begin
                    // Swap on the carrying tick; acc keeps its sum, so phase is continuous.
                    if (tick && acc_carry) begin
                        act_q       <= shadow_q;
                        cfg_ready_q <= 1'b1;
                        state_q     <= CFG_IDLE;
                    end
                end
                default: begin
                    cfg_ready_q <= 1'b1;
                    state_q     <= CFG_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ph1_q  <= '0;
            ph2_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            v1_q  <= tick;
            v2_q  <= v1_q;
            ph2_q <= ph1_q;
            if (tick) begin
                addr_q <= p_top[PT_W-1 -: ADDR_W];
                ph1_q  <= p_top[PT_W-1 -: DATA_W+1];
            end
        end
    end

    dds_wave_shaper #(
        .DATA_W (DATA_W),
        .AMP_W  (AMP_W)
    ) u_shaper (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .valid_i     (v2_q),
        .mode_i      (act_q.mode),
        .amp_i       (act_q.amp),
        .phase_i     (ph2_q),
        .rom_q_i     (rom_q),
        .out_data_o  (out_data),
        .out_valid_o (out_valid)
    );

    assign cfg.cfg_ready = cfg_ready_q;
    assign rom_addr      = addr_q;
    assign wrap          = wrap_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: a modelled 1-clock ROM, hand-derived waveform
// sequences for each mode, immediate/synchronous config, divider and reset checks.
module tb_dds_phase_gen;
    import dds_pkg::*;

    logic             clkin = 1'b0;
    logic             rst_n;
    logic [15:0]      sample_div;
    logic [9:0]       rom_addr;
    logic [7:0]       rom_q;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             wrap;
    cfg_state_e       dbg_state;
    int               total = 0;
    int               bad = 0;

    dds_phase_gen_if #(.ACC_W(32), .ADDR_W(10), .AMP_W(4)) cfg_if ();

    dds_phase_gen dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .sample_div  (sample_div),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .wrap        (wrap),
        .dbg_state_o (dbg_state)
    );

    always #5 clkin = ~clkin;

    function automatic logic [7:0] rom_val(input logic [9:0] a);
        return a[9:2] ^ 8'hA5;
    endfunction

    always @(posedge clkin) rom_q <= rom_val(rom_addr);

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one config word at a negedge; returns at the next negedge after acceptance.
    task automatic cfg_send(input logic [31:0] ftw, input logic [9:0] pow,
                            input logic [3:0] amp, input logic [1:0] mode, input logic sync);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ftw   = ftw;
        cfg_if.cfg_pow   = pow;
        cfg_if.cfg_amp   = amp;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_sync  = sync;
        @(negedge clkin);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic cfg_imm(input logic [31:0] ftw, input logic [9:0] pow,
                           input logic [3:0] amp, input logic [1:0] mode);
        cfg_send(ftw, pow, amp, mode, 1'b0);
        chk("imm_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        @(negedge clkin);
        chk("imm_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    initial begin
        logic found;
        rst_n = 1'b0;
        sample_div = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ftw = '0;
        cfg_if.cfg_pow = '0;
        cfg_if.cfg_amp = '0;
        cfg_if.cfg_mode = '0;
        cfg_if.cfg_sync = 1'b0;

        // Reset state
        @(negedge clkin);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(negedge clkin);
        rst_n = 1'b1;

        // ftw 0 after reset: 3-clock latency, then a sample every clock from ROM[0]
        @(negedge clkin); chk("lat_t1", 32'(out_valid), 32'd0);
        @(negedge clkin); chk("lat_t2", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clkin);
            chk($sformatf("ftw0_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("ftw0_addr_%0d", i), 32'(rom_addr), 32'd0);
            chk($sformatf("ftw0_data_%0d", i), 32'(out_data), 32'hA5);
            chk($sformatf("ftw0_wrap_%0d", i), 32'(wrap), 32'd0);
        end

        // Sine, ftw 2^22: address walks every ROM location, wrap every 1024 clocks
        cfg_imm(32'h0040_0000, 10'd0, 4'hF, MODE_SINE);
        for (int k = 0; k < 2050; k++) begin
            @(negedge clkin);
            chk($sformatf("sine_addr_%0d", k), 32'(rom_addr), 32'(k % 1024));
            chk($sformatf("sine_wrap_%0d", k), 32'(wrap), 32'((k % 1024) == 1023));
            if (k >= 2) chk($sformatf("sine_data_%0d", k), 32'(out_data), 32'(rom_val(10'((k - 2) % 1024))));
        end

        // Square, ftw 2^30: phases 0, 2^30, 2^31, 3*2^30 repeating
        cfg_imm(32'h4000_0000, 10'd0, 4'hF, MODE_SQUARE);
        repeat (2) @(negedge clkin);
        for (int j = 0; j < 12; j++) begin
            @(negedge clkin);
            chk($sformatf("sq_valid_%0d", j), 32'(out_valid), 32'd1);
            chk($sformatf("sq_data_%0d", j), 32'(out_data), ((j % 4) >= 2) ? 32'hFF : 32'h00);
        end

        // Saw, ftw 2^24, amp 7: raw j halves (raw 0x80 -> 0x40)
        cfg_imm(32'h0100_0000, 10'd0, 4'd7, MODE_SAW);
        repeat (2) @(negedge clkin);
        for (int j = 0; j < 256; j++) begin
            @(negedge clkin);
            chk($sformatf("saw7_%0d", j), 32'(out_data), 32'(j / 2));
        end

        // Saw at unity gain: raw passes through (0x80 -> 0x80)
        cfg_imm(32'h0100_0000, 10'd0, 4'hF, MODE_SAW);
        repeat (2) @(negedge clkin);
        for (int j = 0; j < 130; j++) begin
            @(negedge clkin);
            chk($sformatf("saw15_%0d", j), 32'(out_data), 32'(j));
        end

        // Triangle, ftw 2^23: up 0..255 then down 255..0 over one accumulator cycle
        cfg_imm(32'h0080_0000, 10'd0, 4'hF, MODE_TRI);
        repeat (2) @(negedge clkin);
        for (int j = 0; j < 512; j++) begin
            @(negedge clkin);
            chk($sformatf("tri_%0d", j), 32'(out_data), (j < 256) ? 32'(j) : 32'(511 - j));
        end

        // Phase offset alone moves the ROM address
        cfg_imm(32'd0, 10'd5, 4'hF, MODE_SINE);
        @(negedge clkin); chk("pow_addr", 32'(rom_addr), 32'd5);
        repeat (2) @(negedge clkin);
        chk("pow_data", 32'(out_data), 32'hA4);

        // Wrap-synchronous update from ftw 2^30 to 2^31, captured at acc = 2^30
        cfg_imm(32'h4000_0000, 10'd0, 4'hF, MODE_SAW);
        @(negedge clkin);
        cfg_send(32'h8000_0000, 10'd0, 4'hF, MODE_SAW, 1'b1);
        chk("sync_ready_a", 32'(cfg_if.cfg_ready), 32'd0);
        chk("sync_wrap_a", 32'(wrap), 32'd0);
        chk("sync_state", 32'(dbg_state), 32'(CFG_PEND));
        @(negedge clkin);
        chk("sync_ready_b", 32'(cfg_if.cfg_ready), 32'd0);
        chk("sync_wrap_b", 32'(wrap), 32'd0);
        chk("sync_data_0", 32'(out_data), 32'h00);
        @(negedge clkin);
        chk("sync_ready_c", 32'(cfg_if.cfg_ready), 32'd1);
        chk("sync_wrap_c", 32'(wrap), 32'd1);
        chk("sync_data_1", 32'(out_data), 32'h40);
        @(negedge clkin);
        chk("sync_wrap_d", 32'(wrap), 32'd0);
        chk("sync_data_2", 32'(out_data), 32'h80);
        @(negedge clkin);
        chk("sync_wrap_e", 32'(wrap), 32'd1);
        chk("sync_data_3", 32'(out_data), 32'hC0);
        @(negedge clkin); chk("sync_data_4", 32'(out_data), 32'h00);
        @(negedge clkin); chk("sync_data_5", 32'(out_data), 32'h80);
        @(negedge clkin); chk("sync_data_6", 32'(out_data), 32'h00);

        // Divider 3: one sample every 4 clocks
        sample_div = 16'd3;
        repeat (8) @(negedge clkin);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clkin);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("div_found", 32'(found), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clkin);
            chk($sformatf("div_valid_%0d", i), 32'(out_valid), 32'((i % 4) == 0));
        end

        // ftw 0 with a synchronous request never wraps: stays pending
        sample_div = 16'd0;
        cfg_imm(32'd0, 10'd512, 4'hF, MODE_SQUARE);
        repeat (3) @(negedge clkin);
        chk("hold_addr", 32'(rom_addr), 32'd512);
        chk("hold_data", 32'(out_data), 32'hFF);
        chk("hold_valid", 32'(out_valid), 32'd1);
        cfg_send(32'd5, 10'd0, 4'hF, MODE_SAW, 1'b1);
        repeat (20) @(negedge clkin);
        chk("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("pend_state", 32'(dbg_state), 32'(CFG_PEND));
        chk("pend_addr", 32'(rom_addr), 32'd512);

        // Asynchronous reset mid-run clears at once; no stale samples afterwards
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
        chk("mrst_wrap", 32'(wrap), 32'd0);
        chk("mrst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("mrst_state", 32'(dbg_state), 32'(CFG_IDLE));
        repeat (2) @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin); chk("rel_t1", 32'(out_valid), 32'd0);
        @(negedge clkin); chk("rel_t2", 32'(out_valid), 32'd0);
        @(negedge clkin);
        chk("rel_t3", 32'(out_valid), 32'd1);
        chk("rel_data", 32'(out_data), 32'hA5);
        chk("rel_addr", 32'(rom_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
